// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-queued bytes serialised LSB-first with CTS gating.
// Optional even parity bit compiled in with `define UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_DIV   = 417,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  input  logic                 cts_n,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 overflow,
  output logic                 busy,
  output logic                 txd
);

  localparam int TW    = $clog2(CLK_DIV);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [3:0]             cnt, cnt_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic                   txd_q, txd_d;
  logic                   pop;
  logic                   wr_ok;
  logic                   start_ok;
  logic                   tick;
  logic [FIFO_AW:0]       wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [DATA_BITS-1:0]   head;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == (FIFO_AW + 1)'(DEPTH));
  assign wr_ok    = wr_en && !full;
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];
  assign start_ok = !empty && !cts_n;
  assign tick     = (timer == '0);
  assign busy     = (state != S_IDLE);
  assign txd      = txd_q;

  always_comb begin
    state_d = state;
    timer_d = timer;
    cnt_d   = cnt;
    shift_d = shift;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = S_START;
          timer_d = RELOAD;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          timer_d = RELOAD;
          cnt_d   = '0;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_d = RELOAD;
          shift_d = shift >> 1;
          if (cnt == 4'(DATA_BITS - 1)) begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end else begin
          timer_d = timer - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          timer_d = RELOAD;
          cnt_d   = '0;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (cnt == 4'(STOP_BITS - 1)) begin
            cnt_d = '0;
            // Chain straight into the next frame so there is no idle gap.
            if (start_ok) begin
              pop     = 1'b1;
              state_d = S_START;
              timer_d = RELOAD;
              shift_d = head;
`ifdef UART_TX_PARITY_EN
              parity_d = ^head;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d   = cnt + 1'b1;
            timer_d = RELOAD;
          end
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so txd stays a plain register.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      cnt      <= '0;
      shift    <= '0;
      txd_q    <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      cnt    <= cnt_d;
      shift  <= shift_d;
      txd_q  <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queued bytes are checked against frames decoded from txd.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_BITS = 1 + 8 + P + 1;
  localparam int FRAME      = FRAME_BITS * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       cts_n = 1'b1;
  logic       full, empty, overflow, busy, txd;
  logic [2:0] level;

  int total = 0;
  int bad = 0;
  int frames = 0;
  logic [7:0] sb[$];

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .cts_n(cts_n),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .busy(busy), .txd(txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame monitor: samples the middle of each bit after a start edge.
  logic [7:0] mon_got, mon_exp;
  logic       mon_par, mon_stp;
  bit         mon_abort;
  int         mon_b;
  always begin
    @(negedge clk);
    if (!rst && txd === 1'b0) begin
      mon_abort = 0;
      mon_got = '0;
      mon_par = 1'b0;
      mon_stp = 1'b0;
      for (int c = 1; c < FRAME; c++) begin
        @(negedge clk);
        if (rst) mon_abort = 1;
        if (c % CD == 2) begin
          mon_b = c / CD;
          if (mon_b >= 1 && mon_b <= 8) mon_got[mon_b-1] = txd;
          else if (P == 1 && mon_b == 9) mon_par = txd;
          else if (mon_b == FRAME_BITS - 1) mon_stp = txd;
        end
      end
      if (!mon_abort) begin
        frames++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL mon_unexpected_frame got=%h required=none", mon_got);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL mon_data got=%h required=%h", mon_got, mon_exp);
          end
`ifdef UART_TX_PARITY_EN
          total++;
          if (mon_par !== ^mon_exp) begin
            bad++;
            $display("FAIL mon_parity got=%b required=%b", mon_par, ^mon_exp);
          end
`endif
        end
        total++;
        if (mon_stp !== 1'b1) begin
          bad++;
          $display("FAIL mon_stop got=%b required=1", mon_stp);
        end
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] d, input int c);
    int b = c / CD;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic put(input logic [7:0] d, input bit accept);
    wr_data = d;
    wr_en   = 1'b1;
    if (accept) sb.push_back(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy && empty) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_low(output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total += 6;
    if (txd !== 1'b1)      begin bad++; $display("FAIL reset_txd got=%b required=1", txd); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b required=0", full); end
    if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b required=1", empty); end
    if (level !== 3'd0)    begin bad++; $display("FAIL reset_level got=%0d required=0", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b required=0", overflow); end
  endtask

  task automatic test_frame(input logic [7:0] d);
    bit ok;
    cts_n = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL frame_pre_idle got=busy required=idle"); end
    put(d, 1);
    total += 3;
    if (empty !== 1'b0) begin bad++; $display("FAIL frame_empty_after_write got=%b required=0", empty); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL frame_busy_before_pop got=%b required=0", busy); end
    if (txd !== 1'b1)   begin bad++; $display("FAIL frame_txd_before_pop got=%b required=1", txd); end
    @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      total += 2;
      if (txd !== exp_bit(d, c)) begin
        bad++; $display("FAIL frame_txd cyc=%0d got=%b required=%b", c, txd, exp_bit(d, c));
      end
      if (busy !== 1'b1) begin
        bad++; $display("FAIL frame_busy cyc=%0d got=%b required=1", c, busy);
      end
    end
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_end got=%b required=0", busy); end
    if (txd !== 1'b1)  begin bad++; $display("FAIL frame_txd_end got=%b required=1", txd); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int run;
    int f0;
    cts_n = 1'b0;
    wait_idle(ok);
    f0 = frames;
    put(8'h00, 1);
    put(8'hFF, 1);
    run = 0;
    for (int i = 0; i < 500 && (busy || run == 0); i++) begin
      if (busy) run++;
      @(negedge clk);
    end
    total++;
    if (run !== 2 * FRAME) begin bad++; $display("FAIL b2b_busy_run got=%0d required=%0d", run, 2 * FRAME); end
    wait_idle(ok);
    total++;
    if (frames - f0 !== 2) begin bad++; $display("FAIL b2b_frames got=%0d required=2", frames - f0); end
  endtask

  task automatic test_overflow;
    bit ok;
    int f0;
    wait_idle(ok);
    cts_n = 1'b1;
    @(negedge clk);
    f0 = frames;
    for (int i = 0; i < 4; i++) put(8'hA1 + 8'(i), 1);
    total += 2;
    if (full !== 1'b1)     begin bad++; $display("FAIL ovf_full_at4 got=%b required=1", full); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_at4 got=%b required=0", overflow); end
    put(8'hA5, 0);
    total += 4;
    if (level !== 3'd4)    begin bad++; $display("FAIL ovf_level got=%0d required=4", level); end
    if (full !== 1'b1)     begin bad++; $display("FAIL ovf_full got=%b required=1", full); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b required=1", overflow); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL ovf_busy_cts got=%b required=0", busy); end
    cts_n = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ovf_drain_timeout got=busy required=idle"); end
    repeat (2 * FRAME) @(negedge clk);
    total += 3;
    if (frames - f0 !== 4) begin bad++; $display("FAIL ovf_frames got=%0d required=4", frames - f0); end
    if (sb.size() !== 0)   begin bad++; $display("FAIL ovf_sb_left got=%0d required=0", sb.size()); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_still_set got=%b required=1", overflow); end
  endtask

  task automatic test_cts_mid;
    bit ok;
    int f0;
    int viol;
    cts_n = 1'b0;
    wait_idle(ok);
    f0 = frames;
    put(8'h3C, 1);
    put(8'hC3, 1);
    repeat (10) @(negedge clk);
    cts_n = 1'b1;
    wait_busy_low(ok);
    total += 4;
    if (!ok)               begin bad++; $display("FAIL cts_frame1_timeout got=busy required=idle"); end
    if (frames - f0 !== 1) begin bad++; $display("FAIL cts_frame1 got=%0d required=1", frames - f0); end
    if (level !== 3'd1)    begin bad++; $display("FAIL cts_level got=%0d required=1", level); end
    if (txd !== 1'b1)      begin bad++; $display("FAIL cts_txd got=%b required=1", txd); end
    viol = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL cts_hold got=%0d required=0", viol); end
    cts_n = 1'b0;
    wait_idle(ok);
    total++;
    if (frames - f0 !== 2) begin bad++; $display("FAIL cts_frames got=%0d required=2", frames - f0); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int f0;
    cts_n = 1'b0;
    wait_idle(ok);
    f0 = frames;
    put(8'h00, 1);
    put(8'h00, 1);
    put(8'h81, 1);
    repeat (8) @(negedge clk);
    total += 2;
    if (txd !== 1'b0)   begin bad++; $display("FAIL rstmid_pre_txd got=%b required=0", txd); end
    if (level !== 3'd2) begin bad++; $display("FAIL rstmid_pre_level got=%0d required=2", level); end
    #2 rst = 1'b1;
    #1;
    total += 6;
    if (txd !== 1'b1)      begin bad++; $display("FAIL rstmid_txd got=%b required=1", txd); end
    if (level !== 3'd0)    begin bad++; $display("FAIL rstmid_level got=%0d required=0", level); end
    if (empty !== 1'b1)    begin bad++; $display("FAIL rstmid_empty got=%b required=1", empty); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got=%b required=0", overflow); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy got=%b required=0", busy); end
    if (full !== 1'b0)     begin bad++; $display("FAIL rstmid_full got=%b required=0", full); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    sb.delete();
    total++;
    if (frames - f0 !== 0) begin bad++; $display("FAIL rstmid_no_frames got=%0d required=0", frames - f0); end
    put(8'h96, 1);
    wait_idle(ok);
    repeat (4) @(negedge clk);
    total++;
    if (frames - f0 !== 1) begin bad++; $display("FAIL rstmid_recover got=%0d required=1", frames - f0); end
  endtask

  initial begin
    test_reset();
    test_frame(8'h55);
`ifdef UART_TX_PARITY_EN
    test_frame(8'h07);
    test_frame(8'h03);
`endif
    test_frame(8'hB2);
    test_back_to_back();
    test_overflow();
    test_cts_mid();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised buffered UART transmitter for the debug (`dbg_txd`) and Wi‑Fi (`wifi_txd`) serial outputs of the top level. Bus-side writes are queued in an internal FIFO and serialised LSB-first at a fixed clock divider. Configurable data width, stop bits and FIFO depth, with CTS flow control. One instance per serial channel.

## Interface
- `CLK_DIV`, 417, system clocks per bit (48 MHz / 417 ≈ 115200 baud); legal ≥ 2
- `DATA_BITS`, 8, data bits per frame; legal 5..9
- `STOP_BITS`, 1, stop bits per frame; legal 1 or 2
- `FIFO_AW`, 4, FIFO address width; depth = 2^FIFO_AW entries

- `clk` in 1 system clock; one clock domain for the whole block
- `rst` in 1 reset; asynchronous, active-high
- `wr_data` in DATA_BITS byte to queue
- `wr_en` in 1 write strobe, one entry per cycle high
- `cts_n` in 1 clear-to-send, active-low, already synchronised by the caller
- `full` out 1 FIFO holds 2^FIFO_AW entries
- `empty` out 1 FIFO holds 0 entries
- `level` out FIFO_AW+1 entries currently queued; excludes the frame on the wire
- `overflow` out 1 sticky: a write was dropped; cleared only by `rst`
- `busy` out 1 a frame is on the wire (START through last STOP)
- `txd` out 1 serial line; idles high

## Operation
- Reset values: `txd`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0. FIFO pointers zeroed, state IDLE.
- Asserting `rst` mid-frame drives `txd` high immediately. The frame is aborted and the FIFO is flushed.
- FIFO write: accepted when `wr_en`=1 and `full`=0, sampled before the edge. If `wr_en`=1 and `full`=1, the data is dropped and `overflow` is set. This holds even if a pop occurs on the same edge.
- Simultaneous accepted write and pop: `level` is unchanged. Pointers wrap modulo 2^FIFO_AW.
- State machine:
  - IDLE: `txd`=1. If `empty`=0 and `cts_n`=0, pop the head into the shift register, go to START.
  - START: `txd`=0 for CLK_DIV cycles, then DATA.
  - DATA: `txd`=shift[0] for CLK_DIV cycles per bit, shifting right. After DATA_BITS bits go to PARITY (if compiled in), else STOP.
  - PARITY: `txd` = XOR of the data bits (even parity) for CLK_DIV cycles, then STOP.
  - STOP: `txd`=1 for STOP_BITS×CLK_DIV cycles. On the last cycle, if `empty`=0 and `cts_n`=0, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- `cts_n` is sampled only at frame start. Deasserting it mid-frame does not truncate the frame.
- Bit timer: down-counter of width clog2(CLK_DIV), reloaded with CLK_DIV-1 at each bit boundary.

## Timing
- `txd` is registered; there is no combinational path from any input to `txd`.
- Write into an empty FIFO while IDLE with `cts_n`=0:
  - `wr_en` sampled at edge k.
  - `empty` falls after edge k.
  - Pop happens at edge k+1; `txd` falls and `busy` rises after edge k+1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with parity, else 0.
- `busy` falls on the same edge that `txd` enters IDLE. It stays high across back-to-back frames.
- `full`, `empty`, `level` and `overflow` update on the edge after the causing event.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is present, an even parity bit follows the data bits, and the frame is one bit longer.
- `UART_TX_PARITY_EN` undefined: PARITY state and its logic are absent; frame = start + data + stop.

## Test plan
Settings: CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, FIFO_AW=2, parity off unless stated.
- Single byte: write 0x55 with `cts_n`=0.
  - `txd` low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - `busy` high exactly 40 cycles.
- Back-to-back: write 0x00 and 0xFF on consecutive cycles. The second start bit immediately follows the first stop bit; `busy` high 80 contiguous cycles.
- Full/overflow:
  - Hold `cts_n`=1 and write 5 bytes. `level`=4, `full`=1, `overflow`=1; 5th byte absent from the output.
  - Release `cts_n`. Exactly 4 frames, in write order.
- CTS mid-frame: raise `cts_n` during the DATA bits of frame 1 with 2 bytes queued. Frame 1 completes; `txd` stays high until `cts_n`=0.
- Reset mid-frame: assert `rst` in DATA. `txd`=1 with no clock edge; `level`=0, `empty`=1, `overflow`=0.
- Parity (`UART_TX_PARITY_EN`): write 0x07. Parity bit 1, frame 44 cycles. Write 0x03: parity bit 0.
